shift_pipe: RTL and testbench
=============================

# shift_pipe

Parametrised, bidirectional register pipeline: DEPTH stages of WIDTH-bit data, each stage tagged with a valid bit, with per-cycle mode control (hold / shift forward / shift reverse / flush). Generalises the single-bit nonblocking D flip-flop into a multi-stage delay line with stall, direction and occupancy tracking. Sits between a data source and a consumer that needs a fixed or tapped delay, and is the standard delay/skew element for later datapath labs.

## Interface
- WIDTH, 8, data width per stage (>=1)
- DEPTH, 4, number of stages (>=2)
- SELW, $clog2(DEPTH), tap-select width (derived, not overridden)
- clk  in  1  rising-edge clock, single domain
- rst  in  1  asynchronous, active-high reset
- en  in  1  stage enable; 0 forces hold regardless of mode
- mode  in  2  00 hold, 01 shift forward, 10 shift reverse, 11 flush
- d  in  WIDTH  input data word
- d_vld  in  1  valid tag for d
- tap_sel  in  SELW  stage index for tap output
- q_fwd  out  WIDTH  stage[DEPTH-1] data (forward exit)
- q_fwd_vld  out  1  stage[DEPTH-1] valid
- q_rev  out  WIDTH  stage[0] data (reverse exit)
- q_rev_vld  out  1  stage[0] valid
- q_tap  out  WIDTH  stage[tap_sel] data
- q_tap_vld  out  1  stage[tap_sel] valid
- occ  out  $clog2(DEPTH+1)  count of valid stages

## Operation
- State: data[0..DEPTH-1], vld[0..DEPTH-1], occ register; all updated with nonblocking assignment on one clk edge.
- en=0 or mode=00: all state holds.
- mode=01 (forward): stage[0] <= {d, d_vld}; stage[i] <= stage[i-1] for i>=1; stage[DEPTH-1] contents drop out.
- mode=10 (reverse): stage[DEPTH-1] <= {d, d_vld}; stage[i] <= stage[i+1] for i<DEPTH-1; stage[0] contents drop out.
- mode=11 (flush): all data <= 0, all vld <= 0, occ <= 0; d ignored.
- occ update on shift: occ + d_vld - (exiting stage vld). Never exceeds DEPTH, never below 0; implementation keeps occ equal to popcount(vld) at all times.
- Invalid stages still carry and shift data; consumers qualify with *_vld.
- tap_sel >= DEPTH (non-power-of-2 DEPTH): q_tap = 0, q_tap_vld = 0.

## Timing
- Reset (async assert, any time, incl. mid-shift): all data 0, all vld 0, occ 0 immediately; outputs q_fwd, q_rev, q_tap = 0, all *_vld = 0, occ = 0.
- Reset deassert: first active edge after deassert operates normally.
- q_fwd/q_rev/occ are direct register outputs; q_tap/q_tap_vld are a combinational mux of registers (no clock latency from tap_sel).
- Forward latency: d sampled at edge k appears on q_fwd after edge k+DEPTH-1 given DEPTH consecutive forward shifts (DEPTH cycles); stalls (en=0/hold) add cycles 1:1.
- Reverse latency: identical, d to q_rev.
- Appears at stage[0] (q_rev in forward mode) one edge after capture; no combinational path d -> any output.
- Mode change between forward and reverse takes effect on the next edge with no bubbles; in-flight words simply reverse direction.
- en and mode sampled only at rising clk; glitches between edges irrelevant.

## Structure
- Shared package shift_pipe_pkg: mode encodings MODE_HOLD=2'b00, MODE_FWD=2'b01, MODE_REV=2'b10, MODE_FLUSH=2'b11.
- One sub-module shift_stage: single {data, vld} register with async rst, 3:1 next-value mux (hold / from-left / from-right) plus synchronous clear; shift_pipe instantiates DEPTH of them via generate, with d/d_vld as boundary inputs.
- occ counter and tap mux live in shift_pipe top.

## Test plan
- Reset: assert rst mid-run with vld stages populated -> within same cycle all outputs 0, occ=0; release, shift forward 8'hA5 d_vld=1 -> q_rev=8'hA5, occ=1 after one edge.
- Forward fill (WIDTH=8, DEPTH=4): shift 8'h01,02,03,04 valid -> after 4th edge q_fwd=8'h01, q_rev=8'h04, occ=4; 5th shift with d_vld=0 -> q_fwd=8'h02, occ=3.
- Stall: after loading 8'h11,22, hold 3 cycles with en=0 and mode=01 -> outputs and occ unchanged; resume -> latency to q_fwd extended by exactly 3 cycles.
- Reverse: load 8'hAA,BB reverse -> q_fwd=8'hBB, stage[DEPTH-2]=8'hAA; switch to forward one edge -> q_fwd=8'hAA, no word lost or duplicated.
- Tap/boundary: fill 8'h10..13, sweep tap_sel 0..3 -> q_tap=8'h13,12,11,10 with vld=1; DEPTH=3 build with tap_sel=3 -> q_tap=0, q_tap_vld=0.
- Flush: full pipe, mode=11 with d_vld=1 -> next edge all vld=0, occ=0, data 0, d not captured.

Source files
------------

// File: rtl/shift_pipe_pkg.sv
// Shared encodings for the shift_pipe delay line and its stage cells.
package shift_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_FWD   = 2'b01,
    MODE_REV   = 2'b10,
    MODE_FLUSH = 2'b11
  } mode_e;

  // Per-stage next-value source.
  typedef enum logic [1:0] {
    SEL_HOLD  = 2'b00,
    SEL_LEFT  = 2'b01,
    SEL_RIGHT = 2'b10
  } stage_sel_e;

endpackage

// File: rtl/shift_stage.sv
// One {data, vld} register of the pipeline: hold / take left / take right,
// with a synchronous clear that overrides the source select.
module shift_stage
  import shift_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  stage_sel_e       sel_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] left_data_i,
  input  logic             left_vld_i,
  input  logic [WIDTH-1:0] right_data_i,
  input  logic             right_vld_i,
  output logic [WIDTH-1:0] data_o,
  output logic             vld_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d;

  // Next-value mux; clear wins over any shift direction.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (clr_i) begin
      data_d = '0;
      vld_d  = 1'b0;
    end else begin
      unique case (sel_i)
        SEL_LEFT: begin
          data_d = left_data_i;
          vld_d  = left_vld_i;
        end
        SEL_RIGHT: begin
          data_d = right_data_i;
          vld_d  = right_vld_i;
        end
        default: ;
      endcase
    end
  end

  // Stage register with async clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign data_o = data_q;
  assign vld_o  = vld_q;

endmodule

// File: rtl/shift_pipe.sv
// Bidirectional DEPTH-stage delay line with valid tags, occupancy count and
// a combinational tap. d enters at stage 0 going forward, at the last stage
// going reverse.
module shift_pipe
  import shift_pipe_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int SELW  = $clog2(DEPTH),
  localparam int OCCW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             d_vld,
  input  logic [SELW-1:0]  tap_sel,
  output logic [WIDTH-1:0] q_fwd,
  output logic             q_fwd_vld,
  output logic [WIDTH-1:0] q_rev,
  output logic             q_rev_vld,
  output logic [WIDTH-1:0] q_tap,
  output logic             q_tap_vld,
  output logic [OCCW-1:0]  occ
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  stage_sel_e       sel;
  logic             clr;
  logic [OCCW-1:0]  occ_q, occ_d;

  // Decode mode into a common stage select; en low forces hold.
  always_comb begin
    sel = SEL_HOLD;
    clr = 1'b0;
    if (en) begin
      unique case (mode)
        MODE_FWD:   sel = SEL_LEFT;
        MODE_REV:   sel = SEL_RIGHT;
        MODE_FLUSH: clr = 1'b1;
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] left_data, right_data;
    logic             left_vld, right_vld;

    if (i == 0) begin : g_left_in
      assign left_data = d;
      assign left_vld  = d_vld;
    end else begin : g_left_prev
      assign left_data = data_q[i-1];
      assign left_vld  = vld_q[i-1];
    end

    if (i == DEPTH - 1) begin : g_right_in
      assign right_data = d;
      assign right_vld  = d_vld;
    end else begin : g_right_next
      assign right_data = data_q[i+1];
      assign right_vld  = vld_q[i+1];
    end

    shift_stage #(.WIDTH(WIDTH)) u_stage (
      .clk          (clk),
      .rst          (rst),
      .sel_i        (sel),
      .clr_i        (clr),
      .left_data_i  (left_data),
      .left_vld_i   (left_vld),
      .right_data_i (right_data),
      .right_vld_i  (right_vld),
      .data_o       (data_q[i]),
      .vld_o        (vld_q[i])
    );
  end

  // Occupancy tracks popcount(vld): add the entering tag, drop the exiting one.
  // Intermediate wrap at occ=DEPTH cancels out in modular arithmetic.
  always_comb begin
    occ_d = occ_q;
    if (en) begin
      unique case (mode)
        MODE_FWD:   occ_d = occ_q + OCCW'(d_vld) - OCCW'(vld_q[DEPTH-1]);
        MODE_REV:   occ_d = occ_q + OCCW'(d_vld) - OCCW'(vld_q[0]);
        MODE_FLUSH: occ_d = '0;
        default: ;
      endcase
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end

  // Tap mux; out-of-range selects (non-power-of-2 DEPTH) read as empty.
  always_comb begin
    q_tap     = '0;
    q_tap_vld = 1'b0;
    if (int'(tap_sel) < DEPTH) begin
      q_tap     = data_q[tap_sel];
      q_tap_vld = vld_q[tap_sel];
    end
  end

  assign q_fwd     = data_q[DEPTH-1];
  assign q_fwd_vld = vld_q[DEPTH-1];
  assign q_rev     = data_q[0];
  assign q_rev_vld = vld_q[0];
  assign occ       = occ_q;

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: queue-based reference model compared on
// every falling edge, plus hand-computed literal checks from the test plan.
module tb_shift_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic [WIDTH-1:0] d = '0;
  logic             d_vld = 1'b0;
  logic [1:0]       tap_sel = '0;
  logic [1:0]       tap_sel3 = '0;

  logic [WIDTH-1:0] q_fwd, q_rev, q_tap;
  logic             q_fwd_vld, q_rev_vld, q_tap_vld;
  logic [2:0]       occ;

  logic [WIDTH-1:0] q_fwd3, q_rev3, q_tap3;
  logic             q_fwd_vld3, q_rev_vld3, q_tap_vld3;
  logic [1:0]       occ3;

  int errors = 0;
  int checks = 0;

  shift_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .d_vld(d_vld),
    .tap_sel(tap_sel),
    .q_fwd(q_fwd), .q_fwd_vld(q_fwd_vld), .q_rev(q_rev), .q_rev_vld(q_rev_vld),
    .q_tap(q_tap), .q_tap_vld(q_tap_vld), .occ(occ)
  );

  shift_pipe #(.WIDTH(WIDTH), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .d_vld(d_vld),
    .tap_sel(tap_sel3),
    .q_fwd(q_fwd3), .q_fwd_vld(q_fwd_vld3), .q_rev(q_rev3), .q_rev_vld(q_rev_vld3),
    .q_tap(q_tap3), .q_tap_vld(q_tap_vld3), .occ(occ3)
  );

  always #5 clk = ~clk;

  // Reference model: element 0 is the stage nearest the forward entry.
  logic [WIDTH-1:0] m_dat[$];
  logic             m_vld[$];

  task automatic model_clear();
    m_dat = {};
    m_vld = {};
    for (int i = 0; i < DEPTH; i++) begin
      m_dat.push_back('0);
      m_vld.push_back(1'b0);
    end
  endtask

  initial model_clear();

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_clear();
    end else if (en) begin
      case (mode)
        2'b01: begin
          m_dat = {d, m_dat[0:DEPTH-2]};
          m_vld = {d_vld, m_vld[0:DEPTH-2]};
        end
        2'b10: begin
          m_dat = {m_dat[1:DEPTH-1], d};
          m_vld = {m_vld[1:DEPTH-1], d_vld};
        end
        2'b11: model_clear();
        default: ;
      endcase
    end
  end

  function automatic int model_occ();
    int n = 0;
    foreach (m_vld[i]) if (m_vld[i]) n++;
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("m_q_fwd",     32'(q_fwd),     32'(m_dat[DEPTH-1]));
    chk("m_q_fwd_vld", 32'(q_fwd_vld), 32'(m_vld[DEPTH-1]));
    chk("m_q_rev",     32'(q_rev),     32'(m_dat[0]));
    chk("m_q_rev_vld", 32'(q_rev_vld), 32'(m_vld[0]));
    chk("m_q_tap",     32'(q_tap),     32'(m_dat[tap_sel]));
    chk("m_q_tap_vld", 32'(q_tap_vld), 32'(m_vld[tap_sel]));
    chk("m_occ",       32'(occ),       32'(model_occ()));
  end

  task automatic step(input logic e, input logic [1:0] m, input logic [7:0] dd, input logic v);
    en    = e;
    mode  = m;
    d     = dd;
    d_vld = v;
    @(posedge clk);
    #1;
  endtask

  localparam logic [1:0] TMODES [16] = '{1, 1, 2, 0, 1, 2, 2, 1, 3, 1, 1, 1, 2, 1, 2, 1};

  initial begin
    #1 rst = 1'b1;
    #11 rst = 1'b0;

    // Reset values
    chk("rst_q_fwd", 32'(q_fwd), 0);
    chk("rst_occ",   32'(occ),   0);

    // Populate, then async reset between edges
    step(1, 2'b01, 8'h31, 1);
    step(1, 2'b01, 8'h32, 1);
    step(1, 2'b01, 8'h33, 1);
    chk("pre_rst_occ", 32'(occ), 3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_q_rev",     32'(q_rev),     0);
    chk("async_rst_q_rev_vld", 32'(q_rev_vld), 0);
    chk("async_rst_tap_vld",   32'(q_tap_vld), 0);
    chk("async_rst_occ",       32'(occ),       0);
    @(posedge clk);
    #2 rst = 1'b0;
    step(1, 2'b01, 8'hA5, 1);
    chk("post_rst_q_rev", 32'(q_rev), 32'h A5);
    chk("post_rst_occ",   32'(occ),   1);

    // Forward fill
    step(1, 2'b11, 8'h00, 0);
    step(1, 2'b01, 8'h01, 1);
    step(1, 2'b01, 8'h02, 1);
    step(1, 2'b01, 8'h03, 1);
    step(1, 2'b01, 8'h04, 1);
    chk("fill_q_fwd", 32'(q_fwd), 32'h01);
    chk("fill_q_rev", 32'(q_rev), 32'h04);
    chk("fill_occ",   32'(occ),   4);
    step(1, 2'b01, 8'h05, 0);
    chk("fill5_q_fwd", 32'(q_fwd), 32'h02);
    chk("fill5_occ",   32'(occ),   3);

    // Stall with en=0 then resume
    step(1, 2'b11, 8'h00, 0);
    step(1, 2'b01, 8'h11, 1);
    step(1, 2'b01, 8'h22, 1);
    for (int i = 0; i < 3; i++) step(0, 2'b01, 8'hEE, 1);
    chk("stall_q_rev", 32'(q_rev), 32'h22);
    chk("stall_occ",   32'(occ),   2);
    step(1, 2'b01, 8'h00, 0);
    chk("resume1_q_fwd_vld", 32'(q_fwd_vld), 0);
    step(1, 2'b01, 8'h00, 0);
    chk("resume2_q_fwd", 32'(q_fwd), 32'h11);
    chk("resume2_q_fwd_vld", 32'(q_fwd_vld), 1);

    // Reverse then turn around
    step(1, 2'b11, 8'h00, 0);
    step(1, 2'b10, 8'hAA, 1);
    step(1, 2'b10, 8'hBB, 1);
    tap_sel = 2'd2;
    #1;
    chk("rev_q_fwd", 32'(q_fwd), 32'hBB);
    chk("rev_stage2", 32'(q_tap), 32'hAA);
    step(1, 2'b01, 8'h00, 0);
    chk("turn_q_fwd", 32'(q_fwd), 32'hAA);
    chk("turn_occ",   32'(occ),   1);

    // Tap sweep, plus DEPTH=3 boundary
    step(1, 2'b11, 8'h00, 0);
    step(1, 2'b01, 8'h10, 1);
    step(1, 2'b01, 8'h11, 1);
    step(1, 2'b01, 8'h12, 1);
    step(1, 2'b01, 8'h13, 1);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tap_sel = 2'(i);
      #1;
      chk("tap_data", 32'(q_tap), 32'(8'h13 - 8'(i)));
      chk("tap_vld",  32'(q_tap_vld), 1);
    end
    tap_sel3 = 2'd3;
    #1;
    chk("d3_tap_oob",     32'(q_tap3),     0);
    chk("d3_tap_oob_vld", 32'(q_tap_vld3), 0);
    tap_sel3 = 2'd2;
    #1;
    chk("d3_tap2",   32'(q_tap3),   32'h11);
    chk("d3_q_fwd",  32'({q_fwd_vld3, q_fwd3}), 32'h111);
    chk("d3_q_rev",  32'({q_rev_vld3, q_rev3}), 32'h113);
    chk("d3_occ",    32'(occ3),     3);

    // Flush a full pipe with a valid word on d
    step(1, 2'b11, 8'hFF, 1);
    chk("flush_occ",       32'(occ),       0);
    chk("flush_q_rev",     32'(q_rev),     0);
    chk("flush_q_rev_vld", 32'(q_rev_vld), 0);
    chk("flush_q_fwd_vld", 32'(q_fwd_vld), 0);

    // Mixed directed sequence, checked by the model each cycle
    for (int i = 0; i < 16; i++) begin
      tap_sel = 2'(i);
      step((i % 5) != 3, TMODES[i], 8'(i * 8'h13 + 1), ((i & 1) ^ ((i >> 2) & 1)) != 0);
    end
    step(0, 2'b00, 8'h00, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
